// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester, multiplier and response signals around mult_share_arbiter.
// slave = arbiter side, master = surrounding clients, multiplier and consumer.
interface mult_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;

  logic [7:0]        mult_dataa;
  logic [7:0]        mult_datab;
  logic              mult_start;
  logic              mult_done;
  logic [15:0]       mult_product;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [15:0]       rsp_product;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready,
    output mult_dataa, mult_datab, mult_start,
    input  mult_done, mult_product,
    output rsp_valid, rsp_id, rsp_product, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready,
    input  mult_dataa, mult_datab, mult_start,
    output mult_done, mult_product,
    input  rsp_valid, rsp_id, rsp_product, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential 8x8 multiplier between NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add the WAIT-state watchdog (TIMEOUT_CYC cycles).
module mult_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                 clk,
  input  logic                 reset_a,
  mult_share_arbiter_if.slave  bus
);
  localparam int DATA_W = 8;
  localparam int PROD_W = 16;

  if (NREQ != (1 << ID_W) || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("mult_share_arbiter: NREQ must equal 2**ID_W and TIMEOUT_CYC must be positive");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   dataa_q, dataa_d;
  logic [DATA_W-1:0]   datab_q, datab_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                done_q;

  logic                any_req;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     scan_idx;
  logic                done_rise;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                err_q, err_d;
  logic                timeout;

  assign timeout = (state_q == S_WAIT) && (wd_q == WD_W'(TIMEOUT_CYC));
`endif

  // A done level left high from a previous operation must not count; only its rising edge does.
  assign done_rise = bus.mult_done & ~done_q;

  // Scan downward from ptr+NREQ so the last hit is the nearest requester after ptr.
  always_comb begin
    any_req  = 1'b0;
    win      = ptr_q;
    scan_idx = ptr_q;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = ptr_q + ID_W'(k);
      if (bus.req_valid[scan_idx]) begin
        any_req = 1'b1;
        win     = scan_idx;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) state_d = S_RESP;
`ifdef MULT_ARB_TIMEOUT_EN
        else if (timeout) state_d = S_RESP;
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; the grant is gated so nothing is accepted while reset is held
  always_comb begin
    bus.req_ready  = '0;
    bus.mult_start = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req && !reset_a) bus.req_ready[win] = 1'b1;
      end
      S_START: bus.mult_start = 1'b1;
      S_RESP:  bus.rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state: operand/ID latch on grant, product capture, pointer update
  always_comb begin
    ptr_d   = ptr_q;
    dataa_d = dataa_q;
    datab_d = datab_q;
    id_d    = id_q;
    prod_d  = prod_q;
`ifdef MULT_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          dataa_d = bus.req_a[DATA_W*int'(win) +: DATA_W];
          datab_d = bus.req_b[DATA_W*int'(win) +: DATA_W];
          id_d    = win;
        end
      end
      S_START: begin
`ifdef MULT_ARB_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      S_WAIT: begin
`ifdef MULT_ARB_TIMEOUT_EN
        wd_d = wd_q + WD_W'(1);
`endif
        if (done_rise) begin
          prod_d = bus.mult_product;
`ifdef MULT_ARB_TIMEOUT_EN
          err_d  = 1'b0;
`endif
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (timeout) begin
          prod_d = '0;
          err_d  = 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) ptr_d = id_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; ptr resets to NREQ-1 so requester 0 is scanned first
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      ptr_q   <= ID_W'(NREQ - 1);
      dataa_q <= '0;
      datab_q <= '0;
      id_q    <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      dataa_q <= dataa_d;
      datab_q <= datab_d;
      id_q    <= id_d;
      prod_q  <= prod_d;
      done_q  <= bus.mult_done;
`ifdef MULT_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.mult_dataa  = dataa_q;
  assign bus.mult_datab  = datab_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = prod_q;
`ifdef MULT_ARB_TIMEOUT_EN
  assign bus.rsp_err     = err_q;
`else
  assign bus.rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed testbench for mult_share_arbiter with a behavioural sequential multiplier.
// The multiplier can be switched to manual control for stale-done and timeout scenarios.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int TO   = 32;
  localparam int MLAT = 4;

  logic clk = 1'b0;
  logic reset_a;
  int   checks = 0;
  int   errors = 0;

  mult_share_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus();

  mult_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT_CYC(TO)) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Multiplier model: done drops on start, rises MLAT cycles later and then stays high
  logic        mult_auto;
  logic        man_done;
  logic [15:0] man_prod;
  logic        m_done;
  logic [15:0] m_prod;
  int          m_cnt;

  always @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_prod <= 16'h0;
    end else if (bus.mult_start) begin
      m_cnt  <= MLAT;
      m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_prod <= 16'(bus.mult_dataa) * 16'(bus.mult_datab);
      end
    end
  end

  assign bus.mult_done    = mult_auto ? m_done : man_done;
  assign bus.mult_product = mult_auto ? m_prod : man_prod;

  // Event log of grants, start pulses and accepted responses
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     prod;
    logic            err;
  } rsp_t;

  logic [NREQ-1:0] grant_log[$];
  rsp_t            rsp_log[$];
  int              start_cnt = 0;

  always @(negedge clk) begin
    if (!reset_a) begin
      if (bus.req_ready != '0) grant_log.push_back(bus.req_ready);
      if (bus.mult_start) start_cnt = start_cnt + 1;
      if (bus.rsp_valid && bus.rsp_ready)
        rsp_log.push_back('{id: bus.rsp_id, prod: bus.rsp_product, err: bus.rsp_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 4'hF;
    repeat (2) samp();
    checks++;
    if (bus.req_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready);
    end
    checks++;
    if ({bus.mult_dataa, bus.mult_datab, bus.mult_start, bus.rsp_valid,
         bus.rsp_id, bus.rsp_product, bus.rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: a=%h b=%h start=%b rv=%b id=%0d p=%h err=%b want all 0",
               bus.mult_dataa, bus.mult_datab, bus.mult_start, bus.rsp_valid,
               bus.rsp_id, bus.rsp_product, bus.rsp_err);
    end
    step();
    bus.req_valid = 4'h0;
    reset_a = 1'b0;
    samp();
    checks++;
    if ({bus.mult_start, bus.rsp_valid, bus.req_ready} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: start=%b rv=%b ready=%b want 0",
               bus.mult_start, bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_contention();
    int              g0 = grant_log.size();
    int              r0 = rsp_log.size();
    int              exp_id[5] = '{0, 1, 2, 3, 0};
    logic [15:0]     exp_p[5]  = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd3};
    logic [NREQ-1:0] one = 4'b0001;
    step();
    bus.req_a     = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.req_b     = {8'd3, 8'd3, 8'd3, 8'd3};
    bus.req_valid = 4'hF;
    for (int i = 0; i < 400 && (grant_log.size() - g0) < 5; i++) samp();
    step();
    bus.req_valid = 4'h0;
    for (int i = 0; i < 400 && (rsp_log.size() - r0) < 5; i++) samp();
    checks++;
    if (grant_log.size() - g0 != 5 || rsp_log.size() - r0 != 5) begin
      errors++;
      $display("FAIL contention_count: grants=%0d rsps=%0d want 5/5",
               grant_log.size() - g0, rsp_log.size() - r0);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (grant_log[g0 + k] !== (one << exp_id[k])) begin
        errors++;
        $display("FAIL contention_grant%0d: got %b want %b", k, grant_log[g0 + k], one << exp_id[k]);
      end
      checks++;
      if (rsp_log[r0 + k] !== {ID_W'(exp_id[k]), exp_p[k], 1'b0}) begin
        errors++;
        $display("FAIL contention_rsp%0d: id=%0d p=%h err=%b want id=%0d p=%h err=0", k,
                 rsp_log[r0 + k].id, rsp_log[r0 + k].prod, rsp_log[r0 + k].err, exp_id[k], exp_p[k]);
      end
    end
  endtask

  task automatic test_single();
    int s0 = start_cnt;
    int g0 = grant_log.size();
    bit ok;
    step();
    bus.req_a     = 32'h0000_FF00;
    bus.req_b     = 32'h0000_FF00;
    bus.req_valid = 4'b0010;
    samp();
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant: got %b want 0010", bus.req_ready);
    end
    step();
    bus.req_valid = 4'h0;
    samp();
    checks++;
    if ({bus.mult_start, bus.mult_dataa, bus.mult_datab, bus.req_ready} !== {1'b1, 8'hFF, 8'hFF, 4'h0}) begin
      errors++;
      $display("FAIL single_start: start=%b a=%h b=%h ready=%b want 1/FF/FF/0000",
               bus.mult_start, bus.mult_dataa, bus.mult_datab, bus.req_ready);
    end
    wait_rsp(50, ok);
    checks++;
    if ({ok, bus.rsp_id, bus.rsp_product, bus.rsp_err} !== {1'b1, 2'd1, 16'hFE01, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp: seen=%b id=%0d p=%h err=%b want 1/1/FE01/0",
               ok, bus.rsp_id, bus.rsp_product, bus.rsp_err);
    end
    step();
    samp();
    checks++;
    if (bus.rsp_valid !== 1'b0 || start_cnt - s0 != 1 || grant_log.size() - g0 != 1) begin
      errors++;
      $display("FAIL single_once: rv=%b starts=%0d grants=%0d want 0/1/1",
               bus.rsp_valid, start_cnt - s0, grant_log.size() - g0);
    end
  endtask

  task automatic test_backpressure();
    int s0;
    bit ok;
    step();
    bus.rsp_ready = 1'b0;
    bus.req_a     = {8'h05, 8'h00, 8'h00, 8'h10};
    bus.req_b     = {8'h07, 8'h00, 8'h00, 8'h10};
    bus.req_valid = 4'b1001;
    samp();
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_grant: got %b want 1000", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0001;
    wait_rsp(50, ok);
    s0 = start_cnt;
    checks++;
    if ({ok, bus.rsp_id, bus.rsp_product, bus.rsp_err} !== {1'b1, 2'd3, 16'h0023, 1'b0}) begin
      errors++;
      $display("FAIL bp_rsp: seen=%b id=%0d p=%h err=%b want 1/3/0023/0",
               ok, bus.rsp_id, bus.rsp_product, bus.rsp_err);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      samp();
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.req_ready, bus.mult_start}
          !== {1'b1, 2'd3, 16'h0023, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b id=%0d p=%h ready=%b start=%b want 1/3/0023/0000/0",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.req_ready, bus.mult_start);
      end
    end
    step();
    bus.rsp_ready = 1'b1;
    samp();
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== {1'b1, 4'h0}) begin
      errors++;
      $display("FAIL bp_handshake: rv=%b ready=%b want 1/0000", bus.rsp_valid, bus.req_ready);
    end
    step();
    samp();
    checks++;
    if (bus.req_ready !== 4'b0001 || start_cnt != s0) begin
      errors++;
      $display("FAIL bp_next_grant: ready=%b extra_starts=%0d want 0001/0",
               bus.req_ready, start_cnt - s0);
    end
    step();
    bus.req_valid = 4'h0;
    wait_rsp(50, ok);
    checks++;
    if ({ok, bus.rsp_id, bus.rsp_product, bus.rsp_err} !== {1'b1, 2'd0, 16'h0100, 1'b0}) begin
      errors++;
      $display("FAIL bp_second_rsp: seen=%b id=%0d p=%h err=%b want 1/0/0100/0",
               ok, bus.rsp_id, bus.rsp_product, bus.rsp_err);
    end
    step();
  endtask

  task automatic test_stale_done();
    step();
    mult_auto     = 1'b0;
    man_done      = 1'b1;
    man_prod      = 16'hDEAD;
    bus.req_a     = {8'h00, 8'h02, 8'h00, 8'h00};
    bus.req_b     = {8'h00, 8'h09, 8'h00, 8'h00};
    bus.req_valid = 4'b0100;
    samp();
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL stale_grant: got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = 4'h0;
    for (int i = 0; i < 6; i++) begin
      samp();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_high%0d: rsp_valid=%b want 0", i, bus.rsp_valid);
      end
      step();
    end
    man_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      samp();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_low%0d: rsp_valid=%b want 0", i, bus.rsp_valid);
      end
      step();
    end
    man_done = 1'b1;
    man_prod = 16'h0012;
    samp();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_edge_cycle: rsp_valid=%b want 0", bus.rsp_valid);
    end
    step();
    samp();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err} !== {1'b1, 2'd2, 16'h0012, 1'b0}) begin
      errors++;
      $display("FAIL stale_rsp: rv=%b id=%0d p=%h err=%b want 1/2/0012/0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err);
    end
    step();
    mult_auto = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    step();
    mult_auto     = 1'b0;
    man_done      = 1'b0;
    bus.req_a     = {8'h00, 8'd11, 8'h03, 8'h00};
    bus.req_b     = {8'h00, 8'd13, 8'h03, 8'h00};
    bus.req_valid = 4'b0010;
    samp();
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rmw_grant: got %b want 0010", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0100;
    samp();
    step();
    samp();
    step();
    reset_a = 1'b1;
    samp();
    checks++;
    if (bus.req_ready !== 4'h0) begin
      errors++;
      $display("FAIL rmw_reset_ready: got %b want 0000", bus.req_ready);
    end
    checks++;
    if ({bus.mult_dataa, bus.mult_datab, bus.mult_start, bus.rsp_valid,
         bus.rsp_id, bus.rsp_product, bus.rsp_err} !== '0) begin
      errors++;
      $display("FAIL rmw_reset_outputs: a=%h b=%h start=%b rv=%b id=%0d p=%h err=%b want all 0",
               bus.mult_dataa, bus.mult_datab, bus.mult_start, bus.rsp_valid,
               bus.rsp_id, bus.rsp_product, bus.rsp_err);
    end
    step();
    mult_auto = 1'b1;
    reset_a   = 1'b0;
    samp();
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rmw_regrant: got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = 4'h0;
    wait_rsp(50, ok);
    checks++;
    if ({ok, bus.rsp_id, bus.rsp_product, bus.rsp_err} !== {1'b1, 2'd2, 16'h008F, 1'b0}) begin
      errors++;
      $display("FAIL rmw_rsp: seen=%b id=%0d p=%h err=%b want 1/2/008F/0",
               ok, bus.rsp_id, bus.rsp_product, bus.rsp_err);
    end
    step();
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    bit ok;
    step();
    mult_auto     = 1'b0;
    man_done      = 1'b0;
    man_prod      = 16'h0031;
    bus.req_a     = {8'h00, 8'h00, 8'h00, 8'h07};
    bus.req_b     = {8'h00, 8'h00, 8'h00, 8'h07};
    bus.req_valid = 4'b0001;
    samp();
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL to_grant: got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = 4'h0;
`ifdef MULT_ARB_TIMEOUT_EN
    for (int i = 1; i <= 34; i++) begin
      samp();
      if (bus.rsp_valid !== 1'b0) early = 1'b1;
      step();
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL to_early: response before timeout, got 1 want 0");
    end
    samp();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err} !== {1'b1, 2'd0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL to_rsp: rv=%b id=%0d p=%h err=%b want 1/0/0000/1",
               bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err);
    end
    step();
`else
    for (int i = 0; i < 60; i++) begin
      samp();
      if (bus.rsp_valid !== 1'b0) early = 1'b1;
      step();
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL no_to_rsp: response without completion, got 1 want 0");
    end
    man_done = 1'b1;
    wait_rsp(10, ok);
    checks++;
    if ({ok, bus.rsp_id, bus.rsp_product, bus.rsp_err} !== {1'b1, 2'd0, 16'h0031, 1'b0}) begin
      errors++;
      $display("FAIL no_to_late_rsp: seen=%b id=%0d p=%h err=%b want 1/0/0031/0",
               ok, bus.rsp_id, bus.rsp_product, bus.rsp_err);
    end
    step();
`endif
    mult_auto = 1'b1;
  endtask

  initial begin
    reset_a       = 1'b1;
    mult_auto     = 1'b1;
    man_done      = 1'b0;
    man_prod      = 16'h0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_stale_done();
    test_reset_mid_wait();
    test_timeout();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one sequential 8x8 multiplier datapath between NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake, drives the multiplier's operand and start inputs, and detects completion from its done flag. It returns the 16-bit product tagged with the requester ID. It sits between client logic and the multiplier top level, and is the only block that drives the multiplier's operands and start.

## Interface
Parameters:
- NREQ, 4, number of requesters; must equal 2**ID_W
- ID_W, 2, requester-ID width
- TIMEOUT_CYC, 32, watchdog limit in clk cycles (used only with MULT_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_a  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_a  in  8*NREQ  operand A; requester i uses bits [8i+7:8i]
- req_b  in  8*NREQ  operand B, packed the same way
- req_ready  out  NREQ  one-hot acceptance pulse
- mult_dataa  out  8  operand A to the multiplier
- mult_datab  out  8  operand B to the multiplier
- mult_start  out  1  one-cycle start pulse to the multiplier
- mult_done  in  1  multiplier done flag; a level, may stay high between operations
- mult_product  in  16  multiplier result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  ID_W  index of the requester that was served
- rsp_product  out  16  captured product
- rsp_err  out  1  watchdog abort flag

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE, any req_valid set:
  - Winner = first set bit scanning from ptr+1 upward, modulo NREQ.
  - Same cycle: req_ready[winner]=1. Latch the operands into mult_dataa/mult_datab and the winner into rsp_id, then go to START.
- START:
  - mult_start=1 for exactly this cycle, then go to WAIT.
  - Watchdog counter cleared.
- WAIT:
  - Completion = mult_done & ~done_q, where done_q is mult_done registered every cycle. The rising edge is required; a stale high level is not completion.
  - On completion: capture mult_product into rsp_product, set rsp_err=0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_product and rsp_err are held stable.
  - On rsp_valid & rsp_ready: ptr←rsp_id, then go to IDLE.
- req_ready is 0 in every state except the grant cycle in IDLE.
- Requests that arrive while busy wait; a requester must hold req_valid and its operands until its req_ready pulse.
- A requester that drops req_valid before being granted is skipped; this is not an error.
- mult_dataa/mult_datab hold their value from the grant until the next grant. The multiplier samples operands throughout its computation.
- All NREQ requesters valid: grants follow ptr+1, ptr+2, … cyclically, so no requester waits more than NREQ-1 services.
- A single requester that holds req_valid continuously is granted on every IDLE visit.

## Timing
- Reset values, forced immediately while reset_a=1:
  - state=IDLE, ptr=NREQ-1 (requester 0 first)
  - all outputs 0, done_q=0, watchdog=0
- Grant in cycle T → mult_start in T+1 → WAIT from T+2.
- Completion edge seen in cycle C → rsp_valid from C+1.
- Earliest next grant: the cycle after the rsp handshake.
- Reset asserted mid-operation: the transaction is abandoned and no response is issued. reset_a must reset the multiplier too.
- Throughput: one operation per (multiplier latency + 3 + rsp stall) cycles.

## Configuration
- MULT_ARB_TIMEOUT_EN defined:
  - The watchdog counts cycles in WAIT.
  - On reaching TIMEOUT_CYC without completion: go to RESP with rsp_err=1 and rsp_product=16'h0000.
- Not defined:
  - No watchdog logic; rsp_err is tied to 0.
  - WAIT lasts until completion, indefinitely if necessary.

## Test plan
- Reset: reset_a pulse mid-WAIT → all outputs 0 next sample, state IDLE; next request from req 2 is granted normally.
- Single request: req 1, A=8'hFF, B=8'hFF → one req_ready[1] pulse, one mult_start pulse → rsp_id=1, rsp_product=16'hFE01, rsp_err=0.
- Contention: all 4 valid continuously, A=i+1, B=3 → grant order 0,1,2,3,0; products 3,6,9,12,3.
- Backpressure: rsp_ready low 10 cycles → rsp_valid/rsp_id/rsp_product stable, no req_ready and no mult_start; on release, next grant the cycle after the handshake.
- Stale done: mult_done held high before start and through START → no completion until done falls and rises again.
- Timeout (macro on, TIMEOUT_CYC=32): mult_done stuck low → rsp_valid 33 cycles after WAIT entry with rsp_err=1, rsp_product=0. With the macro off, no response appears.
